// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clkdiv_pkg: shared types and helpers for the programmable clock divider
// Rev 1.0
// ----------------------------------------------------------------------------
package clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } chan_state_e;

    // Phase lengths of zero would never terminate a phase, so they become 1.
    function automatic logic [31:0] clamp1(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clkdiv_chan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clkdiv_chan: one divider channel with shadowed, boundary-applied config
// Rev 1.0
// ----------------------------------------------------------------------------
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int DEF_HI = 6,
    parameter int DEF_LO = 6
)(
    input  logic             Clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] hi_i,
    input  logic [CNT_W-1:0] lo_i,
    output logic             clk_out_o,
    output logic             rise_tick_o,
    output logic             pending_o
);

    localparam logic [CNT_W-1:0] c_def_hi = CNT_W'(clamp1(32'(DEF_HI)));
    localparam logic [CNT_W-1:0] c_def_lo = CNT_W'(clamp1(32'(DEF_LO)));

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_hi_q, act_hi_d;
    logic [CNT_W-1:0] act_lo_q, act_lo_d;
    logic [CNT_W-1:0] shd_hi_q, shd_hi_d;
    logic [CNT_W-1:0] shd_lo_q, shd_lo_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             w_boundary;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        act_hi_d   = act_hi_q;
        act_lo_d   = act_lo_q;
        shd_hi_d   = shd_hi_q;
        shd_lo_d   = shd_lo_q;
        pend_d     = pend_q;
        w_boundary = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en_i) begin
                    state_d    = HIGH;
                    w_boundary = 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == act_hi_q - CNT_W'(1)) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOW: begin
                if (cnt_q == act_lo_q - CNT_W'(1)) begin
                    cnt_d = '0;
                    if (en_i) begin
                        state_d    = HIGH;
                        w_boundary = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Boundary consumes the registered shadow; a same-cycle write lands after it.
        if (w_boundary && pend_q) begin
            act_hi_d = shd_hi_q;
            act_lo_d = shd_lo_q;
            pend_d   = 1'b0;
        end
        if (wr_i) begin
            shd_hi_d = CNT_W'(clamp1(32'(hi_i)));
            shd_lo_d = CNT_W'(clamp1(32'(lo_i)));
            pend_d   = 1'b1;
        end

        clk_d  = (state_d == HIGH);
        tick_d = w_boundary;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            act_hi_q <= c_def_hi;
            act_lo_q <= c_def_lo;
            shd_hi_q <= c_def_hi;
            shd_lo_q <= c_def_lo;
            pend_q   <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            act_hi_q <= act_hi_d;
            act_lo_q <= act_lo_d;
            shd_hi_q <= shd_hi_d;
            shd_lo_q <= shd_lo_d;
            pend_q   <= pend_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
        end
    end

    assign clk_out_o   = clk_q;
    assign rise_tick_o = tick_q;
    assign pending_o   = pend_q;

endmodule
`default_nettype wire

// File: rtl/clkdiv_prog.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clkdiv_prog: NUM_CH independent programmable clock dividers
// Rev 1.0
// ----------------------------------------------------------------------------
module clkdiv_prog
    import clkdiv_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 16,
    parameter  int DEF_HI = 6,
    parameter  int DEF_LO = 6,
    localparam int CH_W   = ch_width(NUM_CH)
)(
    input  logic              Clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_hi,
    input  logic [CNT_W-1:0]  cfg_lo,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] rise_tick,
    output logic [NUM_CH-1:0] pending
);

    // Out-of-range channel indices match no instance and are dropped.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        logic w_wr;
        assign w_wr = cfg_wr && (cfg_ch == CH_W'(g));

        clkdiv_chan #(
            .CNT_W  (CNT_W),
            .DEF_HI (DEF_HI),
            .DEF_LO (DEF_LO)
        ) u_chan (
            .Clk         (Clk),
            .reset       (reset),
            .en_i        (en[g]),
            .wr_i        (w_wr),
            .hi_i        (cfg_hi),
            .lo_i        (cfg_lo),
            .clk_out_o   (clk_out[g]),
            .rise_tick_o (rise_tick[g]),
            .pending_o   (pending[g])
        );
    end

endmodule
`default_nettype wire
